// File: rtl/mnist_pkg.sv
// mnist_pkg: shared types and constants for the MNIST output stage.
// Holds the class count, score type, scorer state encoding, the optional
// output bias table and the requantization helper (shift plus clamp).
package mnist_pkg;

   localparam int N_OUT   = 10;
   localparam int SCORE_W = 8;
   localparam int BIAS_W  = 24;

   typedef logic [SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      QUANT = 2'd2,
      HOLD  = 2'd3
   } scorer_state_t;

   // Per-class starting accumulator values, used only when OUT_BIAS_EN is defined.
   localparam logic signed [BIAS_W-1:0] OUT_BIAS [N_OUT] = '{
      24'sd1280,  -24'sd2560, 24'sd0,     24'sd25600, 24'sd70000,
      24'sd128,   24'sd384,   -24'sd1,    24'sd65535, 24'sd511
   };

   // Arithmetic right shift, then clamp to the unsigned score range.
   function automatic score_t requant(input logic signed [31:0] acc, input int shift);
      logic signed [31:0] s;
      s = acc >>> shift;
      if (s < 0)
         return '0;
      else if (s > 32'sd255)
         return {SCORE_W{1'b1}};
      else
         return s[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/output_layer_scorer_rom.sv
// output_weight_rom: synchronous weight ROM for the output layer.
// N_IN rows of N_OUT packed signed weights, taken from the INIT_DATA
// parameter (row i at [i*ROW_W +: ROW_W]); data is valid one cycle after
// addr. Instantiated beside the scorer.
module output_weight_rom
   import mnist_pkg::*;
#(
   parameter int N_IN  = 64,
   parameter int W_W   = 8,
   parameter logic [N_IN*N_OUT*W_W-1:0] INIT_DATA = '0
) (
   input  logic                       clk,
   input  logic [$clog2(N_IN)-1:0]    addr,
   output logic [N_OUT*W_W-1:0]       data
);

   localparam int ROW_W = N_OUT * W_W;

   logic [ROW_W-1:0] mem [N_IN];

   for (genvar i = 0; i < N_IN; i++) begin : g_rows
      assign mem[i] = INIT_DATA[i*ROW_W +: ROW_W];
   end

   // Registered read port.
   // NOTE: ROM storage and its read register carry no reset; contents are constant and a reset would block block-RAM inference.
   always_ff @(posedge clk) begin
      data <= mem[addr];
   end

endmodule

// File: rtl/output_layer_scorer.sv
// output_layer_scorer: final fully-connected MNIST layer.
// Streams N_IN activations per frame, MACs them against ROM weights into
// N_OUT accumulators, then requantizes into held 8-bit scores for argmax.
// Optional macro OUT_BIAS_EN: accumulators start from mnist_pkg::OUT_BIAS
// instead of zero.
module output_layer_scorer
   import mnist_pkg::*;
#(
   parameter int N_IN  = 64,
   parameter int IN_W  = 8,
   parameter int W_W   = 8,
   parameter int ACC_W = 24,
   parameter int SHIFT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_data,
   input  logic                       in_last,
   output logic [$clog2(N_IN)-1:0]    w_addr,
   input  logic [N_OUT*W_W-1:0]       w_data,
   output score_t                     score [0:N_OUT-1],
   output logic                       score_valid,
   input  logic                       score_ready,
   output logic                       frame_err
);

   localparam int AW     = $clog2(N_IN);
   localparam int PROD_W = IN_W + W_W + 1;

   scorer_state_t              state, state_next;
   logic                       run_en;
   logic [AW-1:0]              cnt;
   logic [IN_W-1:0]            act_q;
   logic                       mac_pend;
   logic                       accept, frame_end, release_scores;
   logic signed [ACC_W-1:0]    acc      [N_OUT];
   logic signed [ACC_W-1:0]    acc_init [N_OUT];
   logic signed [PROD_W-1:0]   prod     [N_OUT];

   assign accept         = in_valid & in_ready;
   assign frame_end      = in_last | (cnt == AW'(N_IN - 1));
   assign release_scores = (state == HOLD) & score_ready;
   assign w_addr         = cnt;

   // State register; run_en holds in_ready low until the first edge after reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ACCUM;
         run_en <= 1'b0;
      end else begin
         state  <= state_next;
         run_en <= 1'b1;
      end
   end

   // Next-state logic: frame end, MAC drain, score load, downstream release.
   // NOTE: state_next gets a default first so this block never infers a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         ACCUM: if (accept && frame_end) state_next = DRAIN;
         DRAIN: if (!mac_pend)           state_next = QUANT;
         QUANT:                          state_next = HOLD;
         HOLD:  if (score_ready)         state_next = ACCUM;
         default:                        state_next = ACCUM;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      in_ready    = run_en && (state == ACCUM);
      score_valid = (state == HOLD);
   end

   // Accumulator start values: bias table or zero.
   always_comb begin
      for (int k = 0; k < N_OUT; k++) begin
`ifdef OUT_BIAS_EN
         acc_init[k] = ACC_W'(OUT_BIAS[k]);
`else
         acc_init[k] = '0;
`endif
      end
   end

   // Beat capture, counter, pending-MAC flag and frame length check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         act_q     <= '0;
         mac_pend  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         mac_pend <= accept;
         if (accept) begin
            act_q <= in_data;
            cnt   <= cnt + AW'(1);
            if (frame_end)
               frame_err <= in_last ^ (cnt == AW'(N_IN - 1));
         end
         if (release_scores) begin
            cnt       <= '0;
            frame_err <= 1'b0;
         end
      end
   end

   // Unsigned activation times signed weight, per class.
   always_comb begin
      for (int k = 0; k < N_OUT; k++) begin
         prod[k] = PROD_W'(signed'({1'b0, act_q})) * PROD_W'(signed'(w_data[k*W_W +: W_W]));
      end
   end

   // Accumulators: MAC one cycle after acceptance, restart after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_OUT; k++) acc[k] <= acc_init[k];
      end else if (release_scores) begin
         for (int k = 0; k < N_OUT; k++) acc[k] <= acc_init[k];
      end else if (mac_pend) begin
         for (int k = 0; k < N_OUT; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
      end
   end

   // Score registers load only in QUANT and otherwise hold for the argmax stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_OUT; k++) score[k] <= '0;
      end else if (state == QUANT) begin
         for (int k = 0; k < N_OUT; k++) score[k] <= requant(32'(acc[k]), SHIFT);
      end
   end

endmodule

// File: tb/tb_output_layer_scorer.sv
// tb_output_layer_scorer: scoreboard bench for output_layer_scorer.
// Models the weight ROM, pushes golden scores per frame, and compares them
// when score_valid rises. Honors OUT_BIAS_EN in its golden model.
`timescale 1ns/1ps
module tb_output_layer_scorer;
   import mnist_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_last;
   logic [7:0]   in_data;
   logic [5:0]   w_addr;
   logic [79:0]  w_data;
   score_t       score [0:9];
   logic         score_valid, score_ready, frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   output_layer_scorer #(
      .N_IN(64), .IN_W(8), .W_W(8), .ACC_W(24), .SHIFT(8)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .w_addr(w_addr), .w_data(w_data),
      .score(score), .score_valid(score_valid), .score_ready(score_ready),
      .frame_err(frame_err)
   );

   // Weight ROM model: one-cycle registered read.
   logic [79:0] rom [64];
   int          wgt [64][10];
   int          act [64];
   always @(posedge clk) w_data <= rom[w_addr];

   typedef struct {
      int               id;
      logic [9:0][7:0]  sc;
      logic             err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t last_exp;
   int   frame_id = 0;
   logic sv_prev  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [7:0] clamp8(input int a);
      int s;
      s = a >>> 8;
      if (s < 0)   return 8'd0;
      if (s > 255) return 8'd255;
      return s[7:0];
   endfunction

   task automatic set_weight(input int i, input int k, input int v);
      wgt[i][k] = v;
      rom[i][k*8 +: 8] = 8'(v);
   endtask

   task automatic fill_weights(input int mode);
      // mode 0: random, 1: only class 3 = +1, 2: class0 +127, class1 -1, rest random
      for (int i = 0; i < 64; i++)
         for (int k = 0; k < 10; k++) begin
            int v;
            v = int'($urandom_range(255)) - 128;
            if (mode == 1) v = (k == 3) ? 1 : 0;
            if (mode == 2 && k == 0) v = 127;
            if (mode == 2 && k == 1) v = -1;
            set_weight(i, k, v);
         end
   endtask

   task automatic push_expected(input int n, input logic err);
      exp_t e;
      for (int k = 0; k < 10; k++) begin
         int a;
`ifdef OUT_BIAS_EN
         a = int'(OUT_BIAS[k]);
`else
         a = 0;
`endif
         for (int i = 0; i < n; i++) a += act[i] * wgt[i][k];
         e.sc[k] = clamp8(a);
      end
      frame_id++;
      e.id  = frame_id;
      e.err = err;
      sb.push_back(e);
      last_exp = e;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive_beat(input logic [7:0] d, input logic last);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [9:0][7:0] cur_scores();
      logic [9:0][7:0] c;
      for (int k = 0; k < 10; k++) c[k] = score[k];
      return c;
   endfunction

   task automatic wait_done();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || score_valid) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("done_timeout", 32'(guard < 100), 32'd1);
   endtask

   // n beats; in_last on beat n-1 when use_last, otherwise never.
   task automatic run_frame(input int n, input bit use_last, input int gap_pct,
                            input bit chk_lat, input bit wait_end);
      push_expected(n, use_last ? (n != 64) : 1'b1);
      for (int i = 0; i < n; i++) begin
         if (int'($urandom_range(99)) < gap_pct)
            repeat ($urandom_range(1, 3)) @(negedge clk);
         drive_beat(8'(act[i]), use_last && (i == n - 1));
      end
      if (chk_lat) begin
         @(negedge clk);
         @(negedge clk);
         check("lat_before_3", 32'(score_valid), 32'd0);
         @(negedge clk);
         check("lat_at_3", 32'(score_valid), 32'd1);
      end
      if (wait_end) begin
         wait_done();
         check("held_after_release", 32'(cur_scores() == last_exp.sc), 32'd1);
      end
   endtask

   // Scoreboard monitor: compare on each rising score_valid.
   always @(negedge clk) begin
      if (score_valid && !sv_prev) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            for (int k = 0; k < 10; k++)
               check($sformatf("f%0d_score%0d", mon_e.id, k), 32'(score[k]), 32'(mon_e.sc[k]));
            check($sformatf("f%0d_frame_err", mon_e.id), 32'(frame_err), 32'(mon_e.err));
         end
      end
      sv_prev = score_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_last     = 1'b0;
      score_ready = 1'b1;
      fill_weights(0);
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_score_valid", 32'(score_valid), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_w_addr", 32'(w_addr), 32'd0);
      check("rst_scores_zero", 32'(cur_scores() == '0), 32'd1);
      rst = 1'b0;
      #1;
      check("in_ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("in_ready_after_edge", 32'(in_ready), 32'd1);

      // Zero frame, random weights, latency check
      for (int i = 0; i < 64; i++) act[i] = 0;
      run_frame(64, 1'b1, 0, 1'b1, 1'b1);

      // Single class
      fill_weights(1);
      for (int i = 0; i < 64; i++) act[i] = 255;
      run_frame(64, 1'b1, 0, 1'b1, 1'b1);
      begin
         int da, ea;
         logic [9:0][7:0] c;
         c  = cur_scores();
         da = 0;
         ea = 0;
         for (int k = 1; k < 10; k++) begin
            if (c[k] > c[da]) da = k;
            if (last_exp.sc[k] > last_exp.sc[ea]) ea = k;
         end
         check("argmax_digit", 32'(da), 32'(ea));
      end

      // Clamp high and low
      fill_weights(2);
      run_frame(64, 1'b1, 0, 1'b0, 1'b1);

      // Short frame: in_last at index 9
      fill_weights(0);
      for (int i = 0; i < 64; i++) act[i] = int'($urandom_range(255));
      run_frame(10, 1'b1, 0, 1'b1, 1'b1);

      // 64 beats without in_last
      run_frame(64, 1'b0, 0, 1'b0, 1'b1);

      // Same data, random gaps vs none
      run_frame(64, 1'b1, 0, 1'b0, 1'b1);
      run_frame(64, 1'b1, 40, 1'b1, 1'b1);

      // Backpressure: hold 20 cycles
      score_ready = 1'b0;
      run_frame(64, 1'b1, 20, 1'b0, 1'b0);
      begin
         int guard;
         guard = 0;
         while (!score_valid && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         check("bp_valid_timeout", 32'(guard < 100), 32'd1);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("bp_valid_c%0d", c), 32'(score_valid), 32'd1);
         check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
         check($sformatf("bp_scores_c%0d", c), 32'(cur_scores() == last_exp.sc), 32'd1);
      end
      score_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_after", 32'(in_ready), 32'd1);
      check("bp_valid_after", 32'(score_valid), 32'd0);
      check("bp_scores_kept", 32'(cur_scores() == last_exp.sc), 32'd1);

      // Next frame unaffected by previous one
      fill_weights(0);
      for (int i = 0; i < 64; i++) act[i] = int'($urandom_range(255));
      run_frame(64, 1'b1, 0, 1'b0, 1'b1);

      // Reset mid-frame after 30 beats
      for (int i = 0; i < 30; i++) drive_beat(8'($urandom_range(255)), 1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_valid", 32'(score_valid), 32'd0);
      check("mid_rst_frame_err", 32'(frame_err), 32'd0);
      check("mid_rst_w_addr", 32'(w_addr), 32'd0);
      check("mid_rst_scores_zero", 32'(cur_scores() == '0), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) act[i] = int'($urandom_range(255));
      run_frame(64, 1'b1, 25, 1'b1, 1'b1);

      // Zero frame again after reset (bias start values when enabled)
      for (int i = 0; i < 64; i++) act[i] = 0;
      run_frame(64, 1'b1, 0, 1'b0, 1'b1);

      check("sb_empty_at_end", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
